// File: rtl/gb_pkg.sv
// Shared Game Boy definitions used by the video-side blocks.
// Contents: FF5x register offsets, PPU mode codes and the HDMA state encoding.
package gb_pkg;

  localparam logic [3:0] REG_HDMA1 = 4'h1;
  localparam logic [3:0] REG_HDMA2 = 4'h2;
  localparam logic [3:0] REG_HDMA3 = 4'h3;
  localparam logic [3:0] REG_HDMA4 = 4'h4;
  localparam logic [3:0] REG_HDMA5 = 4'h5;

  localparam logic [1:0] MODE_HBLANK   = 2'b00;
  localparam logic [1:0] MODE_VBLANK   = 2'b01;
  localparam logic [1:0] MODE_OAM      = 2'b10;
  localparam logic [1:0] MODE_TRANSFER = 2'b11;

  typedef enum logic [1:0] {IDLE, GDMA, HWAIT, HBLK} hdma_state_t;

  localparam int BLOCK_BYTES = 16;

endpackage

// File: rtl/hdma_ctrl.sv
// CGB VRAM DMA controller (FF51-FF55): copies 16-byte blocks from the CPU bus into VRAM,
// either all at once (GDMA) or one block per HBlank (HDMA).
module hdma_ctrl
  import gb_pkg::*;
#(
  parameter int CLKS_PER_BYTE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_sel_reg,
  input  logic [3:0]  cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  input  logic [1:0]  mode,
  input  logic        lcd_on,
  output logic        cpu_stall,
  output logic        src_rd,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_data,
  output logic        vram_wr,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_do
);

  localparam int PH_W = (CLKS_PER_BYTE > 2) ? $clog2(CLKS_PER_BYTE) : 1;
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_BYTE - 1);
  localparam logic [PH_W-1:0] PH_WRITE  = PH_W'(1);
  localparam logic [3:0]      BYTE_LAST = 4'(BLOCK_BYTES - 1);

  hdma_state_t     state, st_after;
  logic [15:0]     src_r, src_c;
  logic [12:0]     dst_r, dst_c;
  logic [6:0]      len, len_after;
  logic [1:0]      mode_q;
  logic            stop_q;
  logic [PH_W-1:0] phase;
  logic [3:0]      byte_cnt;

  logic active, byte_done, blk_end, hblank_edge;
  logic wr_reg, wr_len, start, stop_wait, stop_blk;

  assign active      = (state == GDMA) || (state == HBLK);
  assign byte_done   = active && (phase == PH_LAST);
  assign blk_end     = byte_done && (byte_cnt == BYTE_LAST);
  assign hblank_edge = (mode_q == MODE_TRANSFER) && (mode == MODE_HBLANK) && lcd_on;
  assign wr_reg      = cpu_sel_reg && cpu_wr;
  assign wr_len      = wr_reg && (cpu_addr == REG_HDMA5);

  // Block-end bookkeeping is resolved first so that an FF55 write in the same clk
  // is judged against the post-block state and overrides it.
  // NOTE: every always_comb output gets a default up front so no latch is inferred.
  always_comb begin
    st_after  = state;
    len_after = len;
    if (blk_end) begin
      len_after = len - 7'd1;
      if (len == 7'd0)        st_after = IDLE;
      else if (state == HBLK) st_after = stop_q ? IDLE : HWAIT;
    end else if ((state == HWAIT) && hblank_edge) begin
      st_after = HBLK;
    end
  end

  assign start     = wr_len && ((st_after == IDLE) ||
                                (((st_after == HWAIT) || (st_after == HBLK)) && cpu_di[7]));
  assign stop_wait = wr_len && !cpu_di[7] && (st_after == HWAIT);
  assign stop_blk  = wr_len && !cpu_di[7] && (st_after == HBLK);

  // NOTE: sequential state uses non-blocking assignments only; later assignments in
  // this block deliberately override earlier ones (stop/start beat block-end updates).
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      src_r    <= 16'h0000;
      dst_r    <= 13'h0000;
      src_c    <= 16'h0000;
      dst_c    <= 13'h0000;
      len      <= 7'h7F;
      mode_q   <= MODE_HBLANK;
      stop_q   <= 1'b0;
      phase    <= '0;
      byte_cnt <= 4'd0;
    end else begin
      mode_q <= mode;
      if (wr_reg) begin
        case (cpu_addr)
          REG_HDMA1: src_r[15:8] <= cpu_di;
          REG_HDMA2: src_r[7:0]  <= {cpu_di[7:4], 4'h0};
          REG_HDMA3: dst_r[12:8] <= cpu_di[4:0];
          REG_HDMA4: dst_r[7:0]  <= {cpu_di[7:4], 4'h0};
          default: ;
        endcase
      end

      state <= st_after;
      len   <= len_after;
      if (active) begin
        phase <= byte_done ? '0 : phase + PH_W'(1);
        if (byte_done) begin
          src_c    <= src_c + 16'd1;
          dst_c    <= dst_c + 13'd1;
          byte_cnt <= byte_cnt + 4'd1;
        end
      end

      if (stop_blk)  stop_q <= 1'b1;
      if (stop_wait) state  <= IDLE;
      if (start) begin
        len      <= cpu_di[6:0];
        src_c    <= src_r;
        dst_c    <= dst_r;
        phase    <= '0;
        byte_cnt <= 4'd0;
        stop_q   <= 1'b0;
        if (!cpu_di[7])  state <= GDMA;
        else if (lcd_on) state <= HWAIT;
        else             state <= HBLK;
      end
    end
  end

  assign cpu_stall = active;
  assign src_rd    = active && (phase == '0);
  assign src_addr  = src_c;
  assign vram_wr   = active && (phase == PH_WRITE);
  assign vram_addr = dst_c;
  assign vram_do   = src_data;
  assign cpu_do    = (cpu_addr == REG_HDMA5) ? {(state == IDLE), len} : 8'hFF;

endmodule

// File: tb/tb_hdma_ctrl.sv
// Self-checking bench for hdma_ctrl: randomized GDMA/HDMA transfers checked against
// an address-arithmetic model with expected-byte queues, plus directed corner cases.
module tb_hdma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_sel_reg, cpu_wr;
  logic [3:0]  cpu_addr;
  logic [7:0]  cpu_di, cpu_do;
  logic [1:0]  mode;
  logic        lcd_on;
  logic        cpu_stall, src_rd, vram_wr;
  logic [15:0] src_addr;
  logic [7:0]  src_data, vram_do;
  logic [12:0] vram_addr;

  hdma_ctrl #(.CLKS_PER_BYTE(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_sel_reg(cpu_sel_reg), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
    .cpu_di(cpu_di), .cpu_do(cpu_do),
    .mode(mode), .lcd_on(lcd_on), .cpu_stall(cpu_stall),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .vram_wr(vram_wr), .vram_addr(vram_addr), .vram_do(vram_do)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  // Source memory answers one clk after the read strobe.
  always @(posedge clk) if (src_rd) src_data <= mem(src_addr);

  // Reference model: register images, working pointers and remaining-block count.
  logic [15:0] m_src_r, m_src_c;
  logic [12:0] m_dst_r, m_dst_c;
  logic [6:0]  m_len;
  int          m_blocks;
  logic        m_hdma;
  logic [15:0] rd_q[$];
  logic [15:0] wr_src_q[$];
  logic [12:0] wr_dst_q[$];
  int          stall_cycles = 0;
  int          n_wr = 0;

  function automatic logic [7:0] exp55();
    return {(m_blocks == 0), m_len};
  endfunction

  task automatic push_block();
    for (int i = 0; i < 16; i++) begin
      rd_q.push_back(m_src_c);
      wr_src_q.push_back(m_src_c);
      wr_dst_q.push_back(m_dst_c);
      m_src_c = m_src_c + 16'd1;
      m_dst_c = m_dst_c + 13'd1;
    end
    m_len    = m_len - 7'd1;
    m_blocks = m_blocks - 1;
  endtask

  always @(negedge clk) begin
    logic [15:0] s;
    logic [12:0] d;
    if (!reset) begin
      if (cpu_stall) stall_cycles++;
      if (src_rd) begin
        if (rd_q.size() == 0) check("spurious_rd", src_rd, 1'b0);
        else check("rd_addr", src_addr, rd_q.pop_front());
      end
      if (vram_wr) begin
        n_wr++;
        check("wr_stall", cpu_stall, 1'b1);
        if (wr_src_q.size() == 0) check("spurious_wr", vram_wr, 1'b0);
        else begin
          s = wr_src_q.pop_front();
          d = wr_dst_q.pop_front();
          check("wr_addr", vram_addr, d);
          check("wr_data", vram_do, mem(s));
        end
      end
    end
  end

  task automatic reg_wr(input logic [3:0] a, input logic [7:0] v);
    cpu_sel_reg = 1'b1; cpu_addr = a; cpu_di = v; cpu_wr = 1'b1;
    @(negedge clk);
    cpu_sel_reg = 1'b0; cpu_wr = 1'b0; cpu_addr = 4'h5;
    case (a)
      4'h1: m_src_r[15:8] = v;
      4'h2: m_src_r[7:0]  = {v[7:4], 4'h0};
      4'h3: m_dst_r[12:8] = v[4:0];
      4'h4: m_dst_r[7:0]  = {v[7:4], 4'h0};
      default: ;
    endcase
  endtask

  task automatic set_regs(input logic [15:0] s, input logic [12:0] d);
    reg_wr(4'h1, s[15:8]);
    reg_wr(4'h2, s[7:0]);
    reg_wr(4'h3, {3'($urandom_range(0, 7)), d[12:8]});
    reg_wr(4'h4, d[7:0]);
  endtask

  // Model is updated before the write so the expected bytes exist before the first strobe.
  task automatic do_start(input logic [7:0] v);
    m_len    = v[6:0];
    m_blocks = int'(v[6:0]) + 1;
    m_src_c  = m_src_r;
    m_dst_c  = m_dst_r;
    m_hdma   = v[7];
    if (!v[7]) while (m_blocks > 0) push_block();
    else if (!lcd_on) push_block();
    reg_wr(4'h5, v);
  endtask

  task automatic do_stop();
    m_blocks = 0;
    m_hdma   = 1'b0;
    reg_wr(4'h5, 8'h00);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((cpu_stall || wr_src_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_time"}, (n < 5000), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic hblank_pulse();
    if (m_hdma && m_blocks > 0 && lcd_on) push_block();
    mode = 2'b00;
    repeat (40) @(negedge clk);
    mode = 2'($urandom_range(1, 2));
    repeat (3) @(negedge clk);
    mode = 2'b11;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st0, wr0, nb;
    logic [7:0] v;
    reset = 1'b1; cpu_sel_reg = 1'b0; cpu_wr = 1'b0; cpu_addr = 4'h5; cpu_di = 8'h00;
    mode = 2'b11; lcd_on = 1'b1; src_data = 8'h00;
    m_src_r = '0; m_dst_r = '0; m_src_c = '0; m_dst_c = '0; m_len = 7'h7F; m_blocks = 0; m_hdma = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ff55", cpu_do, 8'hFF);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_strobes", {src_rd, vram_wr}, 2'b00);
    reg_wr(4'h1, 8'h12); cpu_addr = 4'h1;
    #1 check("ff51_read", cpu_do, 8'hFF);
    cpu_addr = 4'h5;

    // Directed GDMA: 32 bytes C000 -> 0010, 64 stall clk.
    reg_wr(4'h1, 8'hC0); reg_wr(4'h2, 8'h00); reg_wr(4'h3, 8'h00); reg_wr(4'h4, 8'h10);
    st0 = stall_cycles; wr0 = n_wr;
    do_start(8'h01);
    wait_idle("gdma");
    check("gdma_stall", stall_cycles - st0, 64);
    check("gdma_bytes", n_wr - wr0, 32);
    check("gdma_ff55", cpu_do, 8'hFF);

    for (int k = 0; k < 4; k++) begin
      set_regs(16'($urandom), 13'($urandom));
      v = 8'($urandom_range(0, 2));
      st0 = stall_cycles; wr0 = n_wr;
      do_start(v);
      wait_idle("rgdma");
      check("rgdma_stall", stall_cycles - st0, (int'(v) + 1) * 32);
      check("rgdma_bytes", n_wr - wr0, (int'(v) + 1) * 16);
      check("rgdma_ff55", cpu_do, exp55());
    end

    // HDMA with three blocks; nothing moves while waiting for HBlank.
    wr0 = n_wr;
    do_start(8'h82);
    repeat (20) @(negedge clk);
    check("hwait_quiet", n_wr - wr0, 0);
    check("hwait_ff55", cpu_do, 8'h02);
    for (int b = 0; b < 3; b++) begin
      st0 = stall_cycles;
      hblank_pulse();
      check("hdma_blk_stall", stall_cycles - st0, 32);
      check("hdma_ff55", cpu_do, exp55());
      check("hdma_left", wr_src_q.size(), 0);
    end
    check("hdma_total", n_wr - wr0, 48);

    for (int k = 0; k < 2; k++) begin
      set_regs(16'($urandom), 13'($urandom));
      nb = $urandom_range(1, 3);
      do_start(8'h80 | 8'(nb - 1));
      for (int b = 0; b < nb; b++) begin
        hblank_pulse();
        check("rhdma_ff55", cpu_do, exp55());
      end
      check("rhdma_left", wr_src_q.size(), 0);
    end

    // Stop between blocks.
    set_regs(16'h4000, 13'h0100);
    do_start(8'h85);
    hblank_pulse();
    do_stop();
    check("stop_ff55", cpu_do, 8'h84);
    wr0 = n_wr;
    hblank_pulse();
    hblank_pulse();
    check("stop_quiet", n_wr - wr0, 0);

    // Stop written mid-block: that block still finishes its 16 bytes.
    do_start(8'h85);
    push_block();
    wr0 = n_wr;
    mode = 2'b00;
    repeat (10) @(negedge clk);
    do_stop();
    repeat (40) @(negedge clk);
    mode = 2'b11;
    repeat (3) @(negedge clk);
    check("midstop_bytes", n_wr - wr0, 16);
    check("midstop_ff55", cpu_do, 8'h84);
    hblank_pulse();
    check("midstop_quiet", n_wr - wr0, 16);

    // Address wrap on both pointers.
    reg_wr(4'h1, 8'hFF); reg_wr(4'h2, 8'hF0); reg_wr(4'h3, 8'h1F); reg_wr(4'h4, 8'hF0);
    do_start(8'h01);
    wait_idle("wrap");
    check("wrap_ff55", cpu_do, 8'hFF);

    // LCD off: first block goes without a mode edge.
    lcd_on = 1'b0;
    st0 = stall_cycles;
    do_start(8'h80);
    repeat (40) @(negedge clk);
    check("lcdoff_stall", stall_cycles - st0, 32);
    check("lcdoff_left", wr_src_q.size(), 0);
    check("lcdoff_ff55", cpu_do, 8'hFF);
    lcd_on = 1'b1;

    // Reset in the middle of a GDMA.
    set_regs(16'h8123, 13'h0ABC);
    do_start(8'h03);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    rd_q.delete(); wr_src_q.delete(); wr_dst_q.delete();
    m_src_r = '0; m_dst_r = '0; m_len = 7'h7F; m_blocks = 0; m_hdma = 1'b0;
    @(negedge clk);
    check("mrst_strobes", {src_rd, vram_wr}, 2'b00);
    check("mrst_stall", cpu_stall, 1'b0);
    check("mrst_ff55", cpu_do, 8'hFF);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_idle", {src_rd, vram_wr, cpu_stall}, 3'b000);
    wr0 = n_wr;
    do_start(8'h00);
    wait_idle("post_rst");
    check("post_rst_bytes", n_wr - wr0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
